ca_run_sequencer: RTL and testbench
===================================

CA_RUN_SEQUENCER -- requirements
Module: ca_run_sequencer

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 128, automaton width in cells; multiple of 16.
REQ-002 SHALL have one clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 seed_valid  input  1  seed byte offered.
REQ-006 seed_data  input  8  seed byte.
REQ-007 seed_ready  output  1  seed byte accepted when seed_valid and seed_ready are both high.
REQ-008 start  input  1  begin/restart free-run.
REQ-009 step  input  1  advance exactly one generation.
REQ-010 stop  input  1  halt run.
REQ-011 gen_limit  input  16  generations per run; 0 = unlimited.
REQ-012 rate_div  input  8  one generation every rate_div+1 cycles in RUN.
REQ-013 ca_load  output  1  one-cycle pulse: array loads ca_seed.
REQ-014 ca_seed  output  NUM_CELLS  assembled seed, held stable outside LOADING.
REQ-015 ca_advance  output  1  one-cycle pulse: array computes next generation.
REQ-016 ca_cells  input  NUM_CELLS  current array state.
REQ-017 win_sel  input  log2(NUM_CELLS/16)  readout window index.
REQ-018 win_data  output  16  registered ca_cells[16*win_sel +: 16].
REQ-019 state  output  3  IDLE=0, LOADING=1, ARMED=2, RUN=3, DONE=4.
REQ-020 gen_count  output  16  generations advanced since last ca_load.
REQ-021 done  output  1  high while in DONE.

Function
REQ-022 Seed load SHALL shift ca_seed left 8 bits with seed_data into bits [7:0] per accepted byte; NUM_CELLS/8 bytes per seed.
REQ-023 seed_ready SHALL be 1 in IDLE, LOADING, ARMED, DONE; 0 in RUN.
REQ-024 First accepted byte SHALL move IDLE/ARMED/DONE to LOADING and set byte counter to 1 (bytes restart, prior partial seed discarded).
REQ-025 Acceptance of final byte SHALL, next cycle: state=ARMED, ca_load=1 for exactly one cycle, gen_count=0.
REQ-026 start/step/stop SHALL be ignored in IDLE and LOADING.
REQ-027 ARMED + step SHALL pulse ca_advance next cycle, gen_count+1, remain ARMED.
REQ-028 ARMED + start SHALL enter RUN with divider cleared to 0; start wins over simultaneous step.
REQ-029 RUN: divider SHALL increment each cycle; when divider >= rate_div, pulse ca_advance, gen_count+1, divider to 0; rate_div=0 gives one advance per cycle.
REQ-030 RUN: if gen_limit != 0 and an advance makes gen_count == gen_limit, SHALL enter DONE same edge; no further advances.
REQ-031 gen_limit=0 SHALL free-run; gen_count wraps 0xFFFF -> 0x0000.
REQ-032 RUN + stop SHALL enter ARMED with no advance that cycle, even if divider matched; gen_count held.
REQ-033 seed_valid SHALL be ignored in RUN (seed_ready=0).
REQ-034 DONE + start SHALL pulse ca_load (held ca_seed), clear gen_count, enter ARMED.
REQ-035 ca_load and ca_advance SHALL never be high in the same cycle.
REQ-036 win_data SHALL update every cycle, one-cycle latency from win_sel/ca_cells.

Reset
REQ-037 rst_n low SHALL asynchronously force: state=IDLE, ca_seed=0, byte counter=0, divider=0, gen_count=0, ca_load=0, ca_advance=0, done=0, win_data=0, seed_ready=1.
REQ-038 Reset mid-LOADING or mid-RUN SHALL discard all progress; no ca_load/ca_advance pulse on release.

Verification
REQ-039 16 bytes 0x00..0x0E,0x01 back-to-back -> ca_seed = 0x000102...0E01, one ca_load pulse, state=2, gen_count=0.
REQ-040 ARMED, step pulsed 3 times -> exactly 3 ca_advance pulses, gen_count=3, state=2.
REQ-041 rate_div=3, gen_limit=5, start -> ca_advance every 4th cycle, 5 pulses total, state=4, done=1, gen_count=5.
REQ-042 RUN, rate_div=0, stop coincident with divider match -> no ca_advance that cycle, state=2, gen_count unchanged.
REQ-043 gen_limit=0, gen_count preset to 0xFFFF via 65535 advances -> next advance gives 0x0000, state stays 3.
REQ-044 rst_n low after 7 seed bytes -> state=0, ca_seed=0; fresh 16-byte load then yields only new bytes.

Source files
------------

// File: rtl/ca_run_sequencer.sv
// Sequencer for a cellular-automaton array: it assembles a seed from a byte stream,
// then runs the array by single step or free-run, optionally up to a generation limit.
module ca_run_sequencer #(
  parameter  int NUM_CELLS = 128,
  localparam int WIN_W     = (NUM_CELLS > 16) ? $clog2(NUM_CELLS / 16) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_valid,
  input  logic [7:0]           seed_data,
  output logic                 seed_ready,
  input  logic                 start,
  input  logic                 step,
  input  logic                 stop,
  input  logic [15:0]          gen_limit,
  input  logic [7:0]           rate_div,
  output logic                 ca_load,
  output logic [NUM_CELLS-1:0] ca_seed,
  output logic                 ca_advance,
  input  logic [NUM_CELLS-1:0] ca_cells,
  input  logic [WIN_W-1:0]     win_sel,
  output logic [15:0]          win_data,
  output logic [2:0]           state,
  output logic [15:0]          gen_count,
  output logic                 done
);

  localparam int NUM_BYTES = NUM_CELLS / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADING = 3'd1,
    S_ARMED   = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               cur_state, nxt_state;
  logic [CNT_W-1:0]     byte_cnt, byte_cnt_nxt;
  logic [7:0]           divider, divider_nxt;
  logic [15:0]          gen_count_nxt;
  logic [NUM_CELLS-1:0] ca_seed_nxt;
  logic                 ca_load_nxt, ca_advance_nxt;
  logic                 accept;
  logic [15:0]          gen_inc;

  assign seed_ready = (cur_state != S_RUN);
  assign done       = (cur_state == S_DONE);
  assign state      = cur_state;
  assign accept     = seed_valid && seed_ready;
  assign gen_inc    = gen_count + 16'd1;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_state      = cur_state;
    byte_cnt_nxt   = byte_cnt;
    divider_nxt    = divider;
    gen_count_nxt  = gen_count;
    ca_seed_nxt    = ca_seed;
    ca_load_nxt    = 1'b0;
    ca_advance_nxt = 1'b0;

    case (cur_state)
      S_LOADING: begin
        if (accept) begin
          ca_seed_nxt = {ca_seed[NUM_CELLS-9:0], seed_data};
          if (byte_cnt == CNT_W'(NUM_BYTES - 1)) begin
            nxt_state     = S_ARMED;
            byte_cnt_nxt  = '0;
            ca_load_nxt   = 1'b1;
            gen_count_nxt = '0;
          end else begin
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
          end
        end
      end

      S_RUN: begin
        if (stop) begin
          nxt_state = S_ARMED;
        end else if (start) begin
          divider_nxt = '0;
        end else if (divider >= rate_div) begin
          ca_advance_nxt = 1'b1;
          gen_count_nxt  = gen_inc;
          divider_nxt    = '0;
          if (gen_limit != 16'd0 && gen_inc == gen_limit) nxt_state = S_DONE;
        end else begin
          divider_nxt = divider + 8'd1;
        end
      end

      S_IDLE, S_ARMED, S_DONE: begin
        // A new seed byte restarts loading from any resting state; controls wait.
        if (accept) begin
          nxt_state    = S_LOADING;
          byte_cnt_nxt = CNT_W'(1);
          ca_seed_nxt  = {ca_seed[NUM_CELLS-9:0], seed_data};
        end else if (cur_state == S_ARMED) begin
          if (start) begin
            nxt_state   = S_RUN;
            divider_nxt = '0;
          end else if (step) begin
            ca_advance_nxt = 1'b1;
            gen_count_nxt  = gen_inc;
          end
        end else if (cur_state == S_DONE && start) begin
          nxt_state     = S_ARMED;
          ca_load_nxt   = 1'b1;
          gen_count_nxt = '0;
        end
      end

      default: nxt_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= S_IDLE;
      byte_cnt   <= '0;
      divider    <= '0;
      gen_count  <= '0;
      ca_seed    <= '0;
      ca_load    <= 1'b0;
      ca_advance <= 1'b0;
      win_data   <= '0;
    end else begin
      cur_state  <= nxt_state;
      byte_cnt   <= byte_cnt_nxt;
      divider    <= divider_nxt;
      gen_count  <= gen_count_nxt;
      ca_seed    <= ca_seed_nxt;
      ca_load    <= ca_load_nxt;
      ca_advance <= ca_advance_nxt;
      win_data   <= ca_cells[{win_sel, 4'b0000} +: 16];
    end
  end

endmodule

// File: tb/tb_ca_run_sequencer.sv
// Directed bench for ca_run_sequencer: expected values are queued when stimulus is
// applied and popped against DUT outputs, with pulse monitors on the negative edge.
module tb_ca_run_sequencer;

  localparam int NC = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seed_valid;
  logic [7:0]    seed_data;
  logic          seed_ready;
  logic          start, step, stop;
  logic [15:0]   gen_limit;
  logic [7:0]    rate_div;
  logic          ca_load;
  logic [NC-1:0] ca_seed;
  logic          ca_advance;
  logic [NC-1:0] ca_cells;
  logic [2:0]    win_sel;
  logic [15:0]   win_data;
  logic [2:0]    state;
  logic [15:0]   gen_count;
  logic          done;

  ca_run_sequencer #(.NUM_CELLS(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
    .start(start), .step(step), .stop(stop),
    .gen_limit(gen_limit), .rate_div(rate_div),
    .ca_load(ca_load), .ca_seed(ca_seed), .ca_advance(ca_advance),
    .ca_cells(ca_cells), .win_sel(win_sel), .win_data(win_data),
    .state(state), .gen_count(gen_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int adv_cnt   = 0;
  int load_cnt  = 0;
  int excl_bad  = 0;
  int adv_times[$];

  always @(negedge clk) begin
    if (ca_advance) begin
      adv_cnt++;
      adv_times.push_back(cyc);
    end
    if (ca_load) load_cnt++;
    if (ca_load && ca_advance) excl_bad++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [127:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [127:0] observed);
    exp_t e;
    e.tag = "sb_underflow";
    e.val = '1;
    if (sb.size() > 0) e = sb.pop_front();
    vectors++;
    assert (observed === e.val) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, observed, e.val);
    end
  endtask

  task automatic send_bytes(input logic [127:0] s, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      seed_valid = 1'b1;
      seed_data  = s[8*i +: 8];
      tick();
    end
    seed_valid = 1'b0;
  endtask

  logic [127:0] s1, s2, s3, s4, cw, t;
  int a0, l0, t0;

  initial begin
    rst_n = 1'b0; seed_valid = 1'b0; seed_data = '0;
    start = 1'b0; step = 1'b0; stop = 1'b0;
    gen_limit = '0; rate_div = '0; ca_cells = '0; win_sel = '0;
    #12;
    expect_val("rst_state", 0);      check(state);
    expect_val("rst_seed_ready", 1); check(seed_ready);
    expect_val("rst_ca_seed", 0);    check(ca_seed);
    expect_val("rst_gen_count", 0);  check(gen_count);
    expect_val("rst_done", 0);       check(done);
    expect_val("rst_win_data", 0);   check(win_data);
    expect_val("rst_ca_load", 0);    check(ca_load);
    expect_val("rst_ca_advance", 0); check(ca_advance);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // controls are ignored in IDLE
    start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0; tick();
    expect_val("idle_ignore_state", 0); check(state);
    expect_val("idle_ignore_adv", 0);   check(adv_cnt);

    // reference seed load
    s1 = 128'h000102030405060708090A0B0C0D0E01;
    send_bytes(s1, 15, 0);
    expect_val("load_state", 2);   check(state);
    expect_val("load_pulse", 1);   check(ca_load);
    expect_val("load_seed", s1);   check(ca_seed);
    expect_val("load_gen", 0);     check(gen_count);
    tick();
    expect_val("load_pulse_end", 0); check(ca_load);
    expect_val("load_count", 1);     check(load_cnt);

    // three single steps
    a0 = adv_cnt;
    repeat (3) begin step = 1'b1; tick(); step = 1'b0; tick(); end
    expect_val("step_adv", 3);   check(adv_cnt - a0);
    expect_val("step_gen", 3);   check(gen_count);
    expect_val("step_state", 2); check(state);

    // start ignored mid-LOADING, partial seed replaced
    s2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_bytes(s2, 15, 13);
    a0 = adv_cnt;
    start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
    expect_val("loading_ignore_state", 1); check(state);
    send_bytes(s2, 12, 0);
    expect_val("reload_seed", s2);  check(ca_seed);
    expect_val("reload_gen", 0);    check(gen_count);
    expect_val("loading_ignore_adv", 0); check(adv_cnt - a0);
    tick();

    // paced run to a generation limit
    rate_div = 8'd3; gen_limit = 16'd5;
    adv_times.delete();
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc;
    for (int k = 1; k <= 5; k++) expect_val("run_adv_time", 128'(t0 + 4*k));
    for (int i = 0; i < 200 && !done; i++) tick();
    repeat (10) tick();
    for (int k = 1; k <= 5; k++) begin
      t = (adv_times.size() > 0) ? 128'(adv_times.pop_front()) : '1;
      check(t);
    end
    expect_val("run_no_extra_adv", 0); check(adv_times.size());
    expect_val("limit_state", 4); check(state);
    expect_val("limit_done", 1);  check(done);
    expect_val("limit_gen", 5);   check(gen_count);

    // DONE + start reloads the held seed
    l0 = load_cnt;
    start = 1'b1; tick(); start = 1'b0;
    expect_val("rearm_load", 1);   check(ca_load);
    expect_val("rearm_state", 2);  check(state);
    expect_val("rearm_gen", 0);    check(gen_count);
    expect_val("rearm_seed", s2);  check(ca_seed);
    tick();
    expect_val("rearm_load_count", 1); check(load_cnt - l0);

    // full-rate run, seed bytes ignored, stop on a divider match
    rate_div = 8'd0; gen_limit = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    expect_val("fullrate_gen", 3); check(gen_count);
    seed_valid = 1'b1; seed_data = 8'hAA;
    expect_val("run_seed_ready", 0); check(seed_ready);
    tick(); seed_valid = 1'b0;
    expect_val("run_seed_ignored", s2); check(ca_seed);
    expect_val("run_state", 3);         check(state);
    stop = 1'b1; tick(); stop = 1'b0;
    expect_val("stop_state", 2); check(state);
    expect_val("stop_no_adv", 0); check(ca_advance);
    expect_val("stop_gen", 4);   check(gen_count);
    tick();
    expect_val("stop_gen_held", 4); check(gen_count);

    // generation counter wrap in free-run
    s3 = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_bytes(s3, 15, 0);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (65535) tick();
    expect_val("wrap_pre_gen", 16'hFFFF); check(gen_count);
    expect_val("wrap_pre_state", 3);      check(state);
    tick();
    expect_val("wrap_gen", 0);   check(gen_count);
    expect_val("wrap_state", 3); check(state);
    expect_val("wrap_adv", 1);   check(ca_advance);
    stop = 1'b1; tick(); stop = 1'b0;

    // readout windows, one-cycle latency
    cw = {$urandom(), $urandom(), $urandom(), $urandom()};
    ca_cells = cw;
    for (int i = 0; i < 8; i++) begin
      win_sel = 3'(i);
      expect_val("win_data", 128'(cw[16*i +: 16]));
      tick();
      check(win_data);
    end

    // reset mid-load discards everything
    send_bytes(s1, 15, 9);
    #3 rst_n = 1'b0;
    #1;
    expect_val("midreset_state", 0);  check(state);
    expect_val("midreset_seed", 0);   check(ca_seed);
    expect_val("midreset_ready", 1);  check(seed_ready);
    expect_val("midreset_gen", 0);    check(gen_count);
    @(negedge clk); rst_n = 1'b1;
    l0 = load_cnt; a0 = adv_cnt;
    repeat (3) tick();
    expect_val("release_state", 0);    check(state);
    expect_val("release_pulses", 0);   check((load_cnt - l0) + (adv_cnt - a0));
    s4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_bytes(s4, 15, 0);
    expect_val("fresh_seed", s4);  check(ca_seed);
    expect_val("fresh_state", 2);  check(state);
    tick();

    expect_val("load_adv_exclusive", 0); check(excl_bad);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
